// File: rtl/dmem_access_ctrl_pkg.sv
// dmem_access_ctrl_pkg: shared widths, function codes and controller states
package dmem_access_ctrl_pkg;
  localparam int DATA_WIDTH = 32;
  typedef enum logic [3:0] {ADD, SUB, SLL, SRL, LOAD, STORE, NOP} func_t;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERROR} dmem_state_t;
  function automatic logic is_mem(func_t f);
    return f == LOAD || f == STORE;
  endfunction
endpackage

// File: rtl/dmem_access_ctrl_if.sv
// dmem_access_ctrl_if: execution-unit side (valid/func/rs*/stall/done/err/rd_data) and DMEM port (req/addr/we/wdata/rd/ack)
interface dmem_access_ctrl_if;
  import dmem_access_ctrl_pkg::*;
  logic valid;
  func_t func;
  logic [DATA_WIDTH-1:0] rs1_data, rs2_data, rd_data;
  logic stall, done, err;
  logic dmem_req, dmem_we, dmem_ack;
  logic [DATA_WIDTH-1:0] dmem_addr, dmem_wdata, dmem_rd;
  modport master (
    input valid, func, rs1_data, rs2_data, dmem_rd, dmem_ack,
    output stall, done, err, rd_data, dmem_req, dmem_addr, dmem_we, dmem_wdata
  );
  modport slave (
    output valid, func, rs1_data, rs2_data, dmem_rd, dmem_ack,
    input stall, done, err, rd_data, dmem_req, dmem_addr, dmem_we, dmem_wdata
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequences LOAD/STORE over the DMEM req/ack handshake with an ack timeout
// ports: clk_i clock, arst_i async active-high reset, bus controller side of dmem_access_ctrl_if
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
  input logic clk_i,
  input logic arst_i,
  dmem_access_ctrl_if.master bus
);
  dmem_state_t state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [DATA_WIDTH-1:0] addr, wdata, rd_data;
  logic we, accept, timeout;
  always_comb begin
    accept = state == IDLE && bus.valid && is_mem(bus.func);
    timeout = cnt == CNT_W'(TIMEOUT_CYCLES - 1);
    // an ack arriving on the last allowed cycle still completes the op
    state_nxt = state == IDLE ? (accept ? ACCESS : IDLE) :
                state == ACCESS ? (bus.dmem_ack ? DONE : timeout ? ERROR : ACCESS) : IDLE;
    // stall is combinational on accept, so it must be masked while reset is held
    bus.stall = !arst_i && (accept || state == ACCESS);
    bus.done = state == DONE || state == ERROR;
    bus.err = state == ERROR;
    bus.dmem_req = state == ACCESS;
    bus.dmem_addr = addr;
    bus.dmem_we = we;
    bus.dmem_wdata = wdata;
    bus.rd_data = rd_data;
  end
  always_ff @(posedge clk_i or posedge arst_i)
    if (arst_i) begin
      state <= IDLE;
      cnt <= '0;
      addr <= '0;
      we <= 1'b0;
      wdata <= '0;
      rd_data <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr <= bus.rs1_data;
        we <= bus.func == STORE;
        wdata <= bus.func == STORE ? bus.rs2_data : '0;
        cnt <= '0;
      end
      if (state == ACCESS) cnt <= cnt + 1'b1;
      if (state == ACCESS && bus.dmem_ack && !we) rd_data <= bus.dmem_rd;
      if (state == ERROR) rd_data <= '0;
    end
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: scoreboard bench for dmem_access_ctrl with TIMEOUT_CYCLES=16
module tb_dmem_access_ctrl;
  import dmem_access_ctrl_pkg::*;
  localparam int TO = 16;
  typedef struct {
    logic err;
    logic [31:0] rd;
    int lat;
  } exp_t;
  logic clk = 1'b0;
  logic arst;
  int checks = 0;
  int errors = 0;
  logic [31:0] model_rd;
  exp_t sb[$];
  always #5 clk = ~clk;
  dmem_access_ctrl_if bus();
  dmem_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (.clk_i(clk), .arst_i(arst), .bus(bus));

  task automatic run_op(input func_t f, input logic [31:0] a, input logic [31:0] w,
                        input int ack_c, input logic [31:0] rdv);
    exp_t e;
    exp_t got;
    logic seen;
    logic [31:0] exp_wd;
    exp_wd = f == STORE ? w : 32'h0;
    @(posedge clk); #1;
    bus.valid = 1'b1; bus.func = f; bus.rs1_data = a; bus.rs2_data = w;
    bus.dmem_ack = 1'b0; bus.dmem_rd = $urandom;
    @(negedge clk);
    checks++;
    if (bus.stall !== 1'b1 || bus.dmem_req !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL accept_%s: stall=%b req=%b done=%b, want 1 0 0", f.name(), bus.stall, bus.dmem_req, bus.done);
    end
    checks++;
    if (bus.rd_data !== model_rd) begin
      errors++;
      $display("FAIL rd_data_before_%s: got %h want %h", f.name(), bus.rd_data, model_rd);
    end
    e.err = ack_c < 1 || ack_c > TO;
    e.lat = e.err ? TO + 1 : ack_c + 1;
    e.rd = e.err ? 32'h0 : (f == LOAD ? rdv : model_rd);
    sb.push_back(e);
    model_rd = e.rd;
    seen = 1'b0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(posedge clk); #1;
      bus.dmem_ack = c == ack_c;
      bus.dmem_rd = c == ack_c ? rdv : $urandom;
      @(negedge clk);
      checks++;
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        got = sb.pop_front();
        if (c != got.lat || bus.err !== got.err || bus.dmem_req !== 1'b0 || bus.stall !== 1'b0) begin
          errors++;
          $display("FAIL done_%s: cycle=%0d err=%b req=%b stall=%b, want cycle=%0d err=%b req=0 stall=0",
                   f.name(), c, bus.err, bus.dmem_req, bus.stall, got.lat, got.err);
        end
      end else if (bus.dmem_req !== 1'b1 || bus.stall !== 1'b1 || bus.dmem_addr !== a ||
                   bus.dmem_we !== (f == STORE) || bus.dmem_wdata !== exp_wd) begin
        errors++;
        $display("FAIL access_%s c%0d: req=%b stall=%b addr=%h we=%b wdata=%h, want 1 1 %h %b %h",
                 f.name(), c, bus.dmem_req, bus.stall, bus.dmem_addr, bus.dmem_we, bus.dmem_wdata,
                 a, f == STORE, exp_wd);
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout_%s: no done within 40 cycles, want done at %0d", f.name(), e.lat);
      sb.delete();
    end
  endtask

  task automatic idle_cycles(input int n, input logic v, input func_t f, input logic ack);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.valid = v; bus.func = f; bus.dmem_ack = ack; bus.dmem_rd = $urandom;
      bus.rs1_data = $urandom; bus.rs2_data = $urandom;
      @(negedge clk);
      checks++;
      if (bus.stall !== 1'b0 || bus.dmem_req !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0 ||
          bus.rd_data !== model_rd) begin
        errors++;
        $display("FAIL idle_%s: stall=%b req=%b done=%b err=%b rd=%h, want 0 0 0 0 %h",
                 f.name(), bus.stall, bus.dmem_req, bus.done, bus.err, bus.rd_data, model_rd);
      end
    end
  endtask

  task automatic test_reset();
    arst = 1'b1;
    bus.valid = 1'b1; bus.func = LOAD; bus.rs1_data = 32'h55; bus.rs2_data = 32'h66;
    bus.dmem_ack = 1'b0; bus.dmem_rd = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.stall !== 1'b0 || bus.dmem_req !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0 ||
        bus.rd_data !== 32'h0 || bus.dmem_addr !== 32'h0 || bus.dmem_we !== 1'b0 || bus.dmem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset: stall=%b req=%b done=%b err=%b rd=%h addr=%h we=%b wdata=%h, want all 0",
               bus.stall, bus.dmem_req, bus.done, bus.err, bus.rd_data, bus.dmem_addr, bus.dmem_we, bus.dmem_wdata);
    end
    bus.valid = 1'b0;
    arst = 1'b0;
    model_rd = 32'h0;
    idle_cycles(1, 1'b0, NOP, 1'b0);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    bus.valid = 1'b1; bus.func = LOAD; bus.rs1_data = 32'h40; bus.dmem_ack = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus.dmem_req !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_pre: req=%b want 1", bus.dmem_req);
    end
    @(posedge clk); #1;
    arst = 1'b1;
    bus.valid = 1'b0;
    #1;
    checks++;
    if (bus.dmem_req !== 1'b0 || bus.stall !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: req=%b stall=%b done=%b, want 0 0 0", bus.dmem_req, bus.stall, bus.done);
    end
    @(negedge clk);
    arst = 1'b0;
    model_rd = 32'h0;
    idle_cycles(3, 1'b0, NOP, 1'b0);
    run_op(STORE, 32'h44, 32'hCAFE, 2, 32'h9999);
  endtask

  initial begin
    test_reset();
    run_op(LOAD, 32'h10, 32'h0, 3, 32'hDEADBEEF);
    run_op(STORE, 32'h20, 32'h1234, 1, 32'h7777);
    run_op(LOAD, 32'h30, 32'h0, -1, 32'h0);
    run_op(LOAD, 32'h34, 32'h0, 16, 32'hA5);
    idle_cycles(4, 1'b1, ADD, 1'b1);
    test_reset_mid();
    run_op(LOAD, 32'h100, 32'hFFFF, 1, 32'h1357);
    run_op(STORE, 32'h104, 32'h2468, 2, 32'h5555);
    run_op(LOAD, 32'h108, 32'h0, 5, 32'h0BADF00D);
    run_op(STORE, 32'h10C, 32'hABCD, -1, 32'h0);
    idle_cycles(2, 1'b0, NOP, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
